clock_enable_bank: RTL

Parametrised multi-channel clock-enable generator that sits directly behind the board PLL wrapper and replaces the single fixed divide-by-two toggle flop. It qualifies the PLL lock signal, waits a settle interval, then produces per-channel single-cycle enable pulses and square-wave clock outputs. Divisors are run-time programmable, and updates apply only at period boundaries. Processor, UART and peripheral timing derive from these enables instead of from extra clock domains.

---
 rtl/clkgen_pkg.sv | 18 +
 rtl/clkgen_channel.sv | 79 +++++++
 rtl/clock_enable_bank.sv | 94 +++++++++
 3 files changed

// File: rtl/clkgen_pkg.sv
// Shared types and defaults for the clock-enable bank: FSM state encoding,
// default divisor / settle length, and the divisor clamp (0 behaves as 1).
package clkgen_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } clkgen_state_e;

  localparam int unsigned DEFAULT_DIV_DFLT   = 2;
  localparam int unsigned SETTLE_CYCLES_DFLT = 256;

  function automatic logic [31:0] clamp_div(input logic [31:0] value);
    return (value == '0) ? 32'd1 : value;
  endfunction

endpackage

// File: rtl/clkgen_channel.sv
// One divider channel: divisor, pending divisor, period counter and the
// registered ce / divided-clock outputs. Divisor changes land on period wraps.
module clkgen_channel
  import clkgen_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             run_now,
  input  logic             run_next,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_val,
  output logic             ce,
  output logic             clk_div,
  output logic             pending
);

  logic [DIV_W-1:0] div_q, div_nxt;
  logic [DIV_W-1:0] pend_q, pend_nxt;
  logic [DIV_W-1:0] cnt_q, cnt_nxt;
  logic [DIV_W-1:0] half_nxt;
  logic [DIV_W-1:0] wr_div;
  logic             pend_v_nxt;
  logic             wrap;

  assign wr_div   = DIV_W'(clamp_div(32'(wr_val)));
  assign wrap     = (cnt_q == div_q - DIV_W'(1));
  // ceil(D/2) without widening: floor(D/2) plus the odd bit.
  assign half_nxt = (div_nxt >> 1) + DIV_W'(div_nxt[0]);

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    div_nxt    = div_q;
    pend_nxt   = pend_q;
    pend_v_nxt = pending;
    cnt_nxt    = '0;
    if (run_now) begin
      // Apply the held value on the wrap, or immediately when RUN is being left.
      if (pending && (wrap || !run_next)) begin
        div_nxt    = pend_q;
        pend_v_nxt = 1'b0;
      end
      if (wr) begin
        pend_nxt   = wr_div;
        pend_v_nxt = 1'b1;
      end
      if (run_next && !wrap) cnt_nxt = cnt_q + DIV_W'(1);
    end else begin
      if (pending) begin
        div_nxt    = pend_q;
        pend_v_nxt = 1'b0;
      end
      if (wr) div_nxt = wr_div;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the divisor register is reset too, so every channel restarts at DEFAULT_DIV.
      div_q   <= DIV_W'(clamp_div(32'(DEFAULT_DIV)));
      pend_q  <= '0;
      pending <= 1'b0;
      cnt_q   <= '0;
      ce      <= 1'b0;
      clk_div <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      div_q   <= div_nxt;
      pend_q  <= pend_nxt;
      pending <= pend_v_nxt;
      cnt_q   <= cnt_nxt;
      ce      <= run_next && (cnt_nxt == '0);
      clk_div <= run_next && (cnt_nxt < half_nxt);
    end
  end

endmodule

// File: rtl/clock_enable_bank.sv
// Multi-channel clock-enable generator: lock qualification FSM, settle timer
// and divisor write decode. Define CLKGEN_LOCK_SYNC_EN to synchronise pll_locked.
module clock_enable_bank
  import clkgen_pkg::*;
#(
  parameter  int NUM_CH        = 4,
  parameter  int DIV_W         = 16,
  parameter  int DEFAULT_DIV   = DEFAULT_DIV_DFLT,
  parameter  int SETTLE_CYCLES = SETTLE_CYCLES_DFLT,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock_in,
  input  logic              reset_n,
  input  logic              pll_locked,
  input  logic              div_wr,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [DIV_W-1:0]  div_val,
  output logic              run,
  output logic [NUM_CH-1:0] ce_out,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] div_pending
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  clkgen_state_e state_q, state_nxt;
  logic [SET_W-1:0] settle_q, settle_nxt;
  logic lk;
  logic run_next;

`ifdef CLKGEN_LOCK_SYNC_EN
  logic [1:0] lock_sync_q;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) lock_sync_q <= 2'b00;
    else          lock_sync_q <= {lock_sync_q[0], pll_locked};
  end

  assign lk = lock_sync_q[1];
`else
  assign lk = pll_locked;
`endif

  always_comb begin
    state_nxt  = state_q;
    settle_nxt = '0;
    case (state_q)
      WAIT_LOCK: if (lk) state_nxt = SETTLE;
      SETTLE: begin
        if (!lk)                                       state_nxt = WAIT_LOCK;
        else if (settle_q == SET_W'(SETTLE_CYCLES - 1)) state_nxt = RUN;
        else                                           settle_nxt = settle_q + SET_W'(1);
      end
      RUN:     if (!lk) state_nxt = WAIT_LOCK;
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  assign run_next = (state_nxt == RUN);

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= WAIT_LOCK;
      settle_q <= '0;
      run      <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      settle_q <= settle_nxt;
      run      <= run_next;
    end
  end

  // Out-of-range channel numbers match no instance, so those writes vanish.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_sel;
    assign wr_sel = div_wr && (div_ch == CH_W'(i));

    clkgen_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clock_in (clock_in),
      .reset_n  (reset_n),
      .run_now  (run),
      .run_next (run_next),
      .wr       (wr_sel),
      .wr_val   (div_val),
      .ce       (ce_out[i]),
      .clk_div  (clk_out[i]),
      .pending  (div_pending[i])
    );
  end

endmodule
